// File: rtl/meas_pkg.sv
// -----------------------------------------------------------------------------
// meas_pkg
// Shared definitions for the measurement scheduler:
//   - state encoding for the scheduler FSM
//   - status byte bit positions
//   - field offsets/widths of the 128-bit UART frame
//   - pack_frame(): assembles a frame from latched counts, status and temperature
// No ports (package).
// -----------------------------------------------------------------------------
package meas_pkg;

    // Scheduler FSM state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLEAR = 3'd1;
    localparam state_t S_GATE  = 3'd2;
    localparam state_t S_LATCH = 3'd3;
    localparam state_t S_SEND  = 3'd4;
    localparam state_t S_HALT  = 3'd5;

    // Status byte layout
    localparam int STAT_W           = 8;
    localparam int STAT_TIMEOUT_BIT = 7;
    localparam int STAT_LAST_BIT    = 6;
    localparam int STAT_IDX_LSB     = 0;
    localparam int STAT_IDX_W       = 6;

    // Frame layout: {ch2, ch1, ch0, status, temp, pad}
    localparam int CH_W        = 32;
    localparam int TEMP_W      = 20;
    localparam int PAD_W       = 4;
    localparam int FRAME_W     = 128;
    localparam int FR_PAD_LSB  = 0;
    localparam int FR_TEMP_LSB = 4;
    localparam int FR_STAT_LSB = 24;
    localparam int FR_CH0_LSB  = 32;
    localparam int FR_CH1_LSB  = 64;
    localparam int FR_CH2_LSB  = 96;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [3*CH_W-1:0] cnt,
        input logic [STAT_W-1:0] status,
        input logic [TEMP_W-1:0] temp
    );
        logic [FRAME_W-1:0] f;
        f                           = '0;
        f[FR_PAD_LSB  +: PAD_W]     = '0;
        f[FR_TEMP_LSB +: TEMP_W]    = temp;
        f[FR_STAT_LSB +: STAT_W]    = status;
        f[FR_CH0_LSB  +: CH_W]      = cnt[0      +: CH_W];
        f[FR_CH1_LSB  +: CH_W]      = cnt[CH_W   +: CH_W];
        f[FR_CH2_LSB  +: CH_W]      = cnt[2*CH_W +: CH_W];
        return f;
    endfunction

endpackage

// File: rtl/meas_timer.sv
// -----------------------------------------------------------------------------
// meas_timer
// Loadable down-counter shared by all timed scheduler states. Counts down to
// zero and holds there; a load overrides the count.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle
//   load_val in   W-bit reload value
//   zero     out  count is zero
// -----------------------------------------------------------------------------
module meas_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/meas_sched.sv
// -----------------------------------------------------------------------------
// meas_sched
// Measurement scheduler for a 3-channel ring-oscillator counter. Runs bursts of
// STP_SMPL samples: clear counters, gate for REF_CLK cycles, latch the three
// counts, send one 128-bit frame over the UART, and after the last sample of a
// burst halt the oscillators for HALT_CYC cycles.
// Ports:
//   clk_i          in   clock
//   rst_i          in   synchronous active-high reset
//   enable_i       in   run measurement bursts
//   osc_rst_o      out  one-cycle clear pulse to the oscillator counters
//   osc_halt_o     out  stop the oscillators
//   latch_req_o    out  latch request to all 3 channels
//   latch_ack_i    in   [2:0] per-channel latch ack (level)
//   cnt_latch_i    in   [95:0] latched counts {ch2, ch1, ch0}
//   temp_i         in   [19:0] temperature word
//   tx_busy_i      in   UART transmitter busy
//   tx_start_o     out  one-cycle frame start pulse
//   tx_data_o      out  [127:0] frame {ch2, ch1, ch0, status, temp, 4'h0}
//   err_timeout_o  out  sticky latch-ack timeout flag
// Handshake: tx_start_o is asserted only in a SEND cycle where tx_busy_i=0;
// the FSM leaves SEND on that same edge, so the pulse is exactly one cycle and
// tx_data_o is already stable while it is high.
// -----------------------------------------------------------------------------
module meas_sched
    import meas_pkg::*;
#(
    parameter int REF_CLK     = 10_000_000,
    parameter int STP_SMPL    = 30,
    parameter int HALT_CYC    = 10_000_000,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    output logic         osc_rst_o,
    output logic         osc_halt_o,
    output logic         latch_req_o,
    input  logic [2:0]   latch_ack_i,
    input  logic [95:0]  cnt_latch_i,
    input  logic [19:0]  temp_i,
    input  logic         tx_busy_i,
    output logic         tx_start_o,
    output logic [127:0] tx_data_o,
    output logic         err_timeout_o
);

    // Timer wide enough for the longest of the three timed intervals
    localparam int T_MAX0 = (REF_CLK > HALT_CYC) ? REF_CLK : HALT_CYC;
    localparam int T_MAX  = (T_MAX0 > ACK_TIMEOUT) ? T_MAX0 : ACK_TIMEOUT;
    localparam int TW     = $clog2(T_MAX + 1);

    // Reload values are N-1: the state runs while the count walks N-1..0 and
    // exits on the cycle the count is zero, giving exactly N cycles.
    localparam logic [TW-1:0] GATE_LOAD = TW'(REF_CLK - 1);
    localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] HALT_LOAD = TW'(HALT_CYC - 1);
    localparam logic [STAT_IDX_W-1:0] LAST_IDX = STAT_IDX_W'(STP_SMPL - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [STAT_IDX_W-1:0]   idx;
    logic                    timer_load;
    logic [TW-1:0]           timer_val;
    logic                    timer_zero;
    logic                    all_ack;
    logic                    capture;
    logic                    send_go;
    logic                    last;
    logic [STAT_W-1:0]       status;

    assign all_ack = &latch_ack_i;
    assign last    = (idx == LAST_IDX);
    // Ack has priority over a coinciding timeout (status[7] follows !all_ack)
    assign capture = (state == S_LATCH) && (all_ack || timer_zero);
    assign send_go = (state == S_SEND) && !tx_busy_i;

    always_comb begin
        status                              = '0;
        status[STAT_TIMEOUT_BIT]            = !all_ack;
        status[STAT_LAST_BIT]               = last;
        status[STAT_IDX_LSB +: STAT_IDX_W]  = idx;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable_i) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_GATE;
            S_GATE:  if (timer_zero) state_nxt = S_LATCH;
            S_LATCH: if (capture) state_nxt = S_SEND;
            S_SEND: begin
                if (!tx_busy_i) begin
                    if (last)          state_nxt = S_HALT;
                    else if (enable_i) state_nxt = S_CLEAR;
                    else               state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                if (timer_zero) state_nxt = enable_i ? S_CLEAR : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // No state ever transitions to itself, so any state change is an entry
    always_comb begin
        timer_load = (state_nxt != state);
        timer_val  = '0;
        case (state_nxt)
            S_GATE:  timer_val = GATE_LOAD;
            S_LATCH: timer_val = ACK_LOAD;
            S_HALT:  timer_val = HALT_LOAD;
            default: timer_val = '0;
        endcase
    end

    meas_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            idx           <= '0;
            tx_data_o     <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                tx_data_o <= pack_frame(cnt_latch_i, status, temp_i);
                if (!all_ack) err_timeout_o <= 1'b1;
            end
            // Last sample keeps its index until HALT finishes
            if (send_go && !last) begin
                idx <= enable_i ? idx + 1'b1 : '0;
            end
            if (state == S_HALT && timer_zero) begin
                idx <= '0;
            end
        end
    end

    assign osc_rst_o   = (state == S_CLEAR);
    assign osc_halt_o  = (state == S_IDLE) || (state == S_HALT);
    assign latch_req_o = (state == S_LATCH);
    // Suppressed while reset is asserted so no frame starts in a reset cycle
    assign tx_start_o  = send_go && !rst_i;

endmodule

// File: doc/meas_sched.md
MEAS_SCHED -- requirements
Module: meas_sched

Interface
REQ-001 SHALL have parameter REF_CLK, default 10_000_000, giving the gate window length in clk_i cycles.
REQ-002 SHALL have parameter STP_SMPL, default 30, giving the number of samples per burst before halt; legal range 1..64.
REQ-003 SHALL have parameter HALT_CYC, default 10_000_000, giving the oscillator halt duration in cycles.
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1024, giving the maximum number of cycles to wait for latch acks.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port enable_i, input, 1 bit: run measurement bursts.
REQ-008 SHALL have port osc_rst_o, output, 1 bit: one-cycle clear pulse to the oscillator counters.
REQ-009 SHALL have port osc_halt_o, output, 1 bit: stop the oscillators.
REQ-010 SHALL have port latch_req_o, output, 1 bit: latch request to all 3 channels.
REQ-011 SHALL have port latch_ack_i, input, 3 bits: per-channel latch ack, level.
REQ-012 SHALL have port cnt_latch_i, input, 96 bits: latched counts; ch0 in [31:0], ch1 in [63:32], ch2 in [95:64].
REQ-013 SHALL have port temp_i, input, 20 bits: current temperature word.
REQ-014 SHALL have port tx_busy_i, input, 1 bit: UART transmitter busy.
REQ-015 SHALL have port tx_start_o, output, 1 bit: one-cycle frame start pulse.
REQ-016 SHALL have port tx_data_o, output, 128 bits: frame = {ch2, ch1, ch0, status[7:0], temp[19:0], 4'h0}.
REQ-017 SHALL have port err_timeout_o, output, 1 bit: sticky ack-timeout flag.

Function
REQ-018 SHALL implement states IDLE, CLEAR, GATE, LATCH, SEND, HALT.
REQ-019 In IDLE, osc_halt_o SHALL be 1; when enable_i=1, the FSM SHALL go to CLEAR.
REQ-020 CLEAR SHALL last exactly 1 cycle, with osc_rst_o=1 and osc_halt_o=0, then go to GATE.
REQ-021 GATE SHALL last exactly REF_CLK cycles, with osc_halt_o=0, then go to LATCH.
REQ-022 latch_req_o SHALL be 1 in every LATCH cycle and 0 in every other state.
REQ-023 In LATCH, when &latch_ack_i=1, the block SHALL capture cnt_latch_i and temp_i into tx_data_o and go to SEND.
REQ-024 If ACK_TIMEOUT LATCH cycles elapse without all acks, the block SHALL capture the same way with status[7]=1, set err_timeout_o, and go to SEND.
REQ-025 If all acks and the timeout occur in the same cycle, the ack SHALL win: status[7]=0 and err_timeout_o is unchanged.
REQ-026 Status byte fields SHALL be: [7]=timeout, [6]=last sample of burst, [5:0]=sample index within the burst, 0..STP_SMPL-1.
REQ-027 SEND SHALL wait while tx_busy_i=1, then pulse tx_start_o for exactly 1 cycle on the first cycle in which tx_busy_i=0.
REQ-028 tx_data_o SHALL stay stable from capture until the next capture.
REQ-029 After the tx_start_o pulse, if the sample index equals STP_SMPL-1, the FSM SHALL go to HALT.
REQ-030 Otherwise it SHALL increment the index and go to CLEAR if enable_i=1, or to IDLE if enable_i=0.
REQ-031 HALT SHALL hold osc_halt_o=1 for exactly HALT_CYC cycles, reset the index to 0, then go to CLEAR if enable_i=1, or to IDLE otherwise.
REQ-032 Deasserting enable_i mid-burst SHALL NOT abort a gate; the current frame completes first.
REQ-033 Going to IDLE from SEND SHALL reset the index to 0.
REQ-034 One cycle-count timer SHALL serve GATE, LATCH timeout and HALT; it is reloaded on every state entry.

Reset
REQ-035 On rst_i=1 at a clk_i edge, the FSM SHALL go to IDLE, the index and timer to 0, tx_data_o to 0 and err_timeout_o to 0.
REQ-036 The same reset SHALL set tx_start_o=0, latch_req_o=0, osc_rst_o=0 and osc_halt_o=1.
REQ-037 Reset asserted mid-operation, including LATCH or SEND, SHALL drop all pulses the next cycle and SHALL NOT emit a partial frame.

Structure
REQ-038 Package meas_pkg SHALL hold the state enum, the status bit positions and the frame field offsets/widths.
REQ-039 A single sub-module meas_timer SHALL implement the loadable down-counter with a zero flag; all other logic is inline.

Verification
Benches use REF_CLK=8, STP_SMPL=3, HALT_CYC=5, ACK_TIMEOUT=4.
REQ-040 Scenario: reset, then enable_i=1 -> osc_rst_o pulses once; latch_req_o rises exactly 9 cycles after that pulse.
REQ-041 Scenario: all acks one cycle after latch_req_o, counts 0x11111111/0x22222222/0x33333333, temp 0xABCDE -> tx_data_o = 0x33333333_22222222_11111111_00_ABCDE_0 and one tx_start_o pulse.
REQ-042 Scenario: only ack[1:0] high -> capture after 4 LATCH cycles, status[7]=1, err_timeout_o=1 until rst_i.
REQ-043 Scenario: tx_busy_i high for 20 cycles on SEND entry -> tx_start_o pulses exactly once, on the first tx_busy_i=0 cycle.
REQ-044 Scenario: continuous run -> status bytes 0x00, 0x01, 0x42; osc_halt_o high 5 cycles; then osc_rst_o and index 0.
REQ-045 Scenario: rst_i asserted in LATCH -> next cycle latch_req_o=0, osc_halt_o=1, tx_data_o=0, and no tx_start_o.
